// File: rtl/i2c_pkg.sv
// Shared types and constants for the PCF8591-style I2C ADC responder.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_OUT,
    WR_BYTE,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] PCF_ADDR = 7'h48;

  // Control byte field positions
  localparam int CH_LSB  = 0;
  localparam int CH_MSB  = 1;
  localparam int AUTOINC = 2;

  function automatic logic [7:0] ch_sel(input logic [31:0] data, input logic [1:0] idx);
    logic [7:0] r;
    r = data[7:0];
    case (idx)
      2'd0: r = data[7:0];
      2'd1: r = data[15:8];
      2'd2: r = data[23:16];
      2'd3: r = data[31:24];
      default: r = data[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_adc_responder_if.sv
// Open-drain I2C pad bundle: pad levels in, sda pull-down enable out.
interface i2c_adc_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave  (input scl_i, input sda_i, output sda_oe);
  modport master (output scl_i, output sda_i, input sda_oe);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a FILT_LEN-sample glitch filter with edge strobes.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [2:0] CNT_TC = 3'(FILT_LEN - 1);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic filt_q, filt_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic [2:0] cnt_q, cnt_d;

  // Down-counter reloads whenever the synchronized level agrees with the filtered one
  always_comb begin
    s1_d   = in_i;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (s2_q == filt_q) begin
      cnt_d = CNT_TC;
    end else if (cnt_q == 3'd0) begin
      filt_d = s2_q;
      cnt_d  = CNT_TC;
    end else begin
      cnt_d = cnt_q - 3'd1;
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= CNT_TC;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = filt_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_adc_responder.sv
// I2C target emulating a 4-channel 8-bit ADC with a DAC output register.
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting in address byte
//   ACK_OUT   | holding our ACK low for one scl period
//   WR_BYTE   | shifting in a control/DAC byte
//   RD_BYTE   | driving a sample byte out, MSB first
//   RD_ACK    | sampling the initiator's ACK/NACK
//   WAIT_STOP | not addressed or NACKed; ignore bits
module i2c_adc_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = PCF_ADDR,
  parameter int         FILT_LEN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  i2c_adc_responder_if.slave         bus,
  input  logic [31:0]                ch_data,
  output logic [7:0]                 ctrl_word,
  output logic                       ctrl_valid,
  output logic [7:0]                 dac_out,
  output logic                       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_i    (bus.scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_i    (bus.sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] ctrl_word_q, ctrl_word_d;
  logic       ctrl_valid_q, ctrl_valid_d;
  logic [7:0] dac_q, dac_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;
  logic       do_load;
  logic [7:0] rd_byte;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    first_d      = first_q;
    sda_oe_d     = sda_oe_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    dac_d        = dac_q;
    busy_d       = busy_q;
    ptr_d        = ptr_q;
    do_load      = 1'b0;
    rd_byte      = ch_sel(ch_data, ptr_q);

    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_ev) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, WR_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                first_d  = 1'b1;
                state_d  = ACK_OUT;
              end else begin
                state_d = WAIT_STOP;
              end
            end else begin
              sda_oe_d = 1'b1;
              state_d  = ACK_OUT;
              if (first_q) begin
                ctrl_word_d  = shift_q;
                ctrl_valid_d = 1'b1;
                ptr_d        = shift_q[CH_MSB:CH_LSB];
                first_d      = 1'b0;
              end else begin
                dac_d = shift_q;
              end
            end
          end
        end
        ACK_OUT: begin
          if (scl_fall) begin
            if (rw_q) begin
              do_load = 1'b1;
              state_d = RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          // bit_cnt counts bits already driven; 0 means a byte is still to be loaded
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              do_load = 1'b1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd0;
            if (!sda_lvl) begin
              state_d = RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    if (do_load) begin
      sda_oe_d  = ~rd_byte[7];
      shift_d   = {rd_byte[6:0], 1'b0};
      bit_cnt_d = 4'd1;
      if (ctrl_word_q[AUTOINC]) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      ctrl_word_q  <= 8'h00;
      ctrl_valid_q <= 1'b0;
      dac_q        <= 8'h00;
      busy_q       <= 1'b0;
      ptr_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      first_q      <= first_d;
      sda_oe_q     <= sda_oe_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      dac_q        <= dac_d;
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign ctrl_word  = ctrl_word_q;
  assign ctrl_valid = ctrl_valid_q;
  assign dac_out    = dac_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Bench for i2c_adc_responder: bit-banged initiator, behavioural ADC model, queue scoreboard.
module tb_i2c_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic [31:0] ch_data = 32'h0;
  logic [7:0]  ctrl_word;
  logic        ctrl_valid;
  logic [7:0]  dac_out;
  logic        busy;

  always #10 clk = ~clk;

  i2c_adc_responder_if bus_if ();
  assign sda_bus      = sda_m & ~bus_if.sda_oe;
  assign bus_if.scl_i = scl_m;
  assign bus_if.sda_i = sda_bus;

  i2c_adc_responder #(.DEV_ADDR(7'h48), .FILT_LEN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .ch_data    (ch_data),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .dac_out    (dac_out),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q        = 20;
  int ctrl_pushed = 0;
  int ctrl_pulses = 0;
  int oe_seen  = 0;
  bit watch_oe = 1'b0;

  // Reference model of the ADC's visible registers
  logic [7:0] m_ctrl = 8'h00;
  logic [7:0] m_dac  = 8'h00;
  int         m_ptr  = 0;

  logic [7:0] exp_ctrl_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic q_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q_wait(q);
    scl_m = 1'b1; q_wait(q);
    sda_m = 1'b0; q_wait(q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    q_wait(q); sda_m = 1'b0;
    q_wait(q); scl_m = 1'b1;
    q_wait(q); sda_m = 1'b1;
    q_wait(q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    q_wait(q); sda_m = b;
    q_wait(q); scl_m = 1'b1;
    q_wait(q); s = sda_bus;
    q_wait(q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_lvl);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack_lvl);
  endtask

  task automatic recv_byte(input bit give_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(give_ack ? 1'b0 : 1'b1, s);
  endtask

  task automatic wr_xfer(input bit do_stop);
    logic s;
    bus_start();
    send_byte(8'h90, s);
    check("wr_addr_ack", s, 0);
    check("busy_set", busy, 1);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == 0) begin
        m_ctrl = tx_q[i];
        m_ptr  = int'(tx_q[i][1:0]);
        exp_ctrl_q.push_back(tx_q[i]);
        ctrl_pushed++;
      end else begin
        m_dac = tx_q[i];
      end
      send_byte(tx_q[i], s);
      check("wr_data_ack", s, 0);
      if (i > 0) check("dac_out", dac_out, m_dac);
    end
    if (do_stop) begin
      check("busy_hold", busy, 1);
      bus_stop();
      check("busy_clear", busy, 0);
    end
  endtask

  task automatic rd_xfer(input int n);
    logic       s;
    logic [7:0] got;
    bus_start();
    send_byte(8'h91, s);
    check("rd_addr_ack", s, 0);
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(ch_data[8*m_ptr +: 8]);
      if (m_ctrl[2]) m_ptr = (m_ptr + 1) % 4;
      recv_byte(k != n - 1, got);
      rx_q.push_back(got);
    end
    q_wait(q);
    check("rd_release_after_nack", bus_if.sda_oe, 0);
    bus_stop();
    check("busy_clear", busy, 0);
  endtask

  // Monitor: every ctrl_valid pulse must match the next expected control byte
  initial begin
    forever begin
      @(negedge clk);
      if (ctrl_valid) begin
        ctrl_pulses++;
        if (exp_ctrl_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ctrl_valid_unexpected: ctrl_word 0x%0h, no pulse expected", ctrl_word);
        end else begin
          check("ctrl_word", ctrl_word, exp_ctrl_q.pop_front());
        end
      end
    end
  end

  // Monitor: bytes received by the initiator against model predictions
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_byte_unexpected: got 0x%0h, expected none", got);
        end else begin
          check("rd_byte", got, exp_rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (watch_oe && bus_if.sda_oe) oe_seen++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic       s;
    logic [7:0] r;
    int         n;

    repeat (5) @(posedge clk);
    #2;
    check("rst_sda_oe", bus_if.sda_oe, 0);
    check("rst_ctrl_word", ctrl_word, 8'h00);
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_dac_out", dac_out, 8'h00);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    q_wait(10);

    // Control write at 100 kHz
    q = 125;
    tx_q.delete(); tx_q.push_back(8'h42);
    wr_xfer(1'b1);
    q = 20;

    // Fixed channel, repeated start into read, ACK then NACK
    ch_data = 32'h44_33_22_11;
    tx_q.delete(); tx_q.push_back(8'h02);
    wr_xfer(1'b0);
    rd_xfer(2);

    // Auto-increment with wrap
    tx_q.delete(); tx_q.push_back(8'h04);
    wr_xfer(1'b1);
    rd_xfer(5);

    // DAC bytes after control byte
    tx_q.delete(); tx_q.push_back(8'h40); tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    wr_xfer(1'b1);
    check("ctrl_word_kept", ctrl_word, m_ctrl);

    // Foreign address: never acknowledged, sda never pulled
    oe_seen = 0;
    watch_oe = 1'b1;
    bus_start();
    send_byte(8'h92, s);
    check("foreign_addr_nack", s, 1);
    check("foreign_busy", busy, 0);
    send_byte(8'h55, s);
    check("foreign_data_nack", s, 1);
    bus_stop();
    watch_oe = 1'b0;
    check("foreign_oe_cycles", oe_seen, 0);
    check("foreign_ctrl_kept", ctrl_word, m_ctrl);

    // STOP after half a control byte
    bus_start();
    send_byte(8'h90, s);
    check("partial_addr_ack", s, 0);
    r = 8'h77;
    for (int i = 7; i >= 4; i--) bus_bit(r[i], s);
    bus_stop();
    check("partial_ctrl_kept", ctrl_word, m_ctrl);
    check("partial_busy", busy, 0);
    check("partial_sda_oe", bus_if.sda_oe, 0);

    // Reset while the responder drives a read bit low
    ch_data = 32'hC3_96_5A_11;
    tx_q.delete(); tx_q.push_back(8'h00);
    wr_xfer(1'b1);
    bus_start();
    send_byte(8'h91, s);
    check("rst_rd_addr_ack", s, 0);
    q_wait(q);
    check("rd_drive_msb_low", bus_if.sda_oe, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sda_oe", bus_if.sda_oe, 0);
    check("midrst_ctrl_word", ctrl_word, 8'h00);
    check("midrst_ctrl_valid", ctrl_valid, 0);
    check("midrst_dac_out", dac_out, 8'h00);
    check("midrst_busy", busy, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    m_ctrl = 8'h00;
    m_dac  = 8'h00;
    m_ptr  = 0;
    q_wait(5);
    rst_n = 1'b1;
    q_wait(10);

    // Read with no control byte since reset uses channel 0
    ch_data = $urandom;
    rd_xfer(2);

    for (int it = 0; it < 5; it++) begin
      ch_data = $urandom;
      tx_q.delete();
      tx_q.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) tx_q.push_back(8'($urandom_range(0, 255)));
      wr_xfer($urandom_range(0, 1) == 1);
      n = int'($urandom_range(1, 4));
      rd_xfer(n);
    end

    q_wait(10);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("ctrl_queue_drained", exp_ctrl_q.size(), 0);
    check("ctrl_pulse_count", ctrl_pulses, ctrl_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
